// File: rtl/pc_fetch.sv
// Program counter and instruction fetch stage: fetches one instruction per step over a
// req/ack memory handshake, decodes fields for alu_control and applies its PC result.
module pc_fetch #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   OP_SIZE   = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter int                   MAX_WAIT  = 255,
    parameter logic [OP_SIZE-1:0]   OP_JUMP   = {OP_SIZE{1'b1}}
) (
    input  logic                 tclk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [OP_SIZE-1:0]   sel,
    output logic [WORD_SIZE-1:0] data1_out,
    output logic [WORD_SIZE-1:0] data2_out,
    output logic [WORD_SIZE-1:0] data3_out,
    output logic                 instr_valid,
    input  logic                 exec_done,
    input  logic                 load_pc,
    input  logic                 offset,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 fetch_err
);

    localparam int IMM_W = WORD_SIZE - OP_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ISSUE,
        UPDATE,
        HALT
    } state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [7:0]           wait_q;
    logic                 mem_req_q, instr_valid_q, fetch_err_q;
    logic [OP_SIZE-1:0]   sel_q, sel_d;
    logic [WORD_SIZE-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;

    // Next PC (load beats offset) and decode of the word currently on the read bus.
    always_comb begin
        pc_d = pc_q + WORD_SIZE'(1);
        if (load_pc) begin
            pc_d = data_in;
        end else if (offset) begin
            pc_d = pc_q + data_in;
        end
        sel_d = mem_rdata[WORD_SIZE-1 -: OP_SIZE];
        d1_d  = (sel_d == OP_JUMP) ? WORD_SIZE'(mem_rdata[IMM_W-1:0])
                                   : WORD_SIZE'(mem_rdata[11:8]);
        d2_d  = WORD_SIZE'(mem_rdata[7:4]);
        d3_d  = WORD_SIZE'(mem_rdata[3:0]);
    end

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            wait_q        <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            sel_q         <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            d3_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        wait_q    <= '0;
                    end
                end
                REQ: begin
                    // An ack arriving on the final wait cycle still completes the fetch.
                    if (mem_ack) begin
                        state_q       <= ISSUE;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        wait_q        <= '0;
                        sel_q         <= sel_d;
                        d1_q          <= d1_d;
                        d2_q          <= d2_d;
                        d3_q          <= d3_d;
                    end else if (wait_q == 8'(MAX_WAIT - 1)) begin
                        state_q     <= HALT;
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        state_q       <= UPDATE;
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (run) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        wait_q    <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign sel         = sel_q;
    assign data1_out   = d1_q;
    assign data2_out   = d2_q;
    assign data3_out   = d3_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: behavioural model checked every cycle, memory and execute responders,
// and directed scenarios with literal expectations.
module tb_pc_fetch;

    localparam int MAXW = 255;
    localparam int JUMP = 15;

    logic        tclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack;
    logic [3:0]  sel;
    logic [15:0] data1_out, data2_out, data3_out;
    logic        instr_valid;
    logic        exec_done;
    logic        load_pc = 1'b0;
    logic        offset = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] pc;
    logic        fetch_err;

    logic ack_r = 1'b0, ack_en = 1'b1, force_ack = 1'b0;
    logic exec_r = 1'b0, force_exec = 1'b0;
    assign mem_ack   = ack_r | force_ack;
    assign exec_done = exec_r | force_exec;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [15:0] mem [int];

    typedef struct {
        bit          ld;
        bit          of;
        logic [15:0] d;
    } op_t;
    op_t exec_q[$];

    pc_fetch dut (
        .tclk(tclk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sel(sel), .data1_out(data1_out), .data2_out(data2_out), .data3_out(data3_out),
        .instr_valid(instr_valid), .exec_done(exec_done), .load_pc(load_pc),
        .offset(offset), .data_in(data_in), .pc(pc), .fetch_err(fetch_err)
    );

    always #5 tclk = ~tclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'h0000;
    endfunction

    // Memory responder: acks the first request cycle when enabled.
    initial forever begin
        @(posedge tclk);
        #2;
        ack_r     = ack_en && mem_req;
        mem_rdata = rd(mem_addr);
    end

    // Execute responder: one exec_done pulse per issued instruction, from the op queue.
    initial forever begin
        op_t o;
        @(posedge tclk);
        #2;
        if (instr_valid && !exec_r && exec_q.size() > 0) begin
            o       = exec_q.pop_front();
            load_pc = o.ld;
            offset  = o.of;
            data_in = o.d;
            exec_r  = 1'b1;
        end else begin
            exec_r = 1'b0;
        end
    end

    // Behavioural model: what the fetch stage is doing, as a set of activity flags.
    bit fetching, issued, updating, halted, m_err;
    int age, m_pc, m_instr;

    task automatic model_reset();
        fetching = 0; issued = 0; updating = 0; halted = 0; m_err = 0;
        age = 0; m_pc = 0; m_instr = 0;
    endtask

    always @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (halted) begin
            halted = 1;
        end else if (fetching) begin
            if (mem_ack) begin
                m_instr  = int'(mem_rdata);
                fetching = 0;
                issued   = 1;
            end else begin
                age = age + 1;
                if (age == MAXW) begin
                    halted   = 1;
                    m_err    = 1;
                    fetching = 0;
                end
            end
        end else if (issued) begin
            if (exec_done) begin
                if (load_pc) m_pc = int'(data_in);
                else if (offset) m_pc = (m_pc + int'(data_in)) % 65536;
                else m_pc = (m_pc + 1) % 65536;
                issued   = 0;
                updating = 1;
            end
        end else if (updating) begin
            updating = 0;
            if (run) begin
                fetching = 1;
                age = 0;
            end
        end else if (run) begin
            fetching = 1;
            age = 0;
        end
    end

    initial forever begin
        int op, d1;
        @(negedge tclk);
        if (chk_en) begin
            op = m_instr / 4096;
            d1 = (op == JUMP) ? m_instr % 4096 : (m_instr / 256) % 16;
            chk("cyc mem_req", {31'd0, mem_req}, {31'd0, fetching});
            chk("cyc mem_addr", {16'd0, mem_addr}, m_pc);
            chk("cyc pc", {16'd0, pc}, m_pc);
            chk("cyc instr_valid", {31'd0, instr_valid}, {31'd0, issued});
            chk("cyc sel", {28'd0, sel}, op);
            chk("cyc data1", {16'd0, data1_out}, d1);
            chk("cyc data2", {16'd0, data2_out}, (m_instr / 16) % 16);
            chk("cyc data3", {16'd0, data3_out}, m_instr % 16);
            chk("cyc fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge tclk);
            #2;
        end
    endtask

    // which: 0 = instr_valid, 1 = mem_req
    task automatic wait_sig(input int which, input string nm);
        int k = 0;
        while (!((which == 0) ? instr_valid : mem_req) && k < 50) begin
            cyc(1);
            k++;
        end
        if (k >= 50) begin
            tests++;
            fails++;
            $display("FAIL %s: timed out after %0d cycles", nm, k);
        end
    endtask

    task automatic push(input bit ld, input bit of, input logic [15:0] d);
        op_t o;
        o.ld = ld; o.of = of; o.d = d;
        exec_q.push_back(o);
    endtask

    initial begin
        int n;
        mem[0]     = 16'h1123;
        mem[1]     = 16'h2456;
        mem[2]     = 16'h7000;
        mem[16'h40]   = 16'h5A5A;
        mem[16'h100]  = {4'hF, 12'hABC};
        mem[16'hFFFF] = 16'h3210;

        cyc(2);
        chk_en = 1'b1;
        chk("rst mem_req", {31'd0, mem_req}, 0);
        chk("rst pc", {16'd0, pc}, 0);
        chk("rst instr_valid", {31'd0, instr_valid}, 0);
        chk("rst sel", {28'd0, sel}, 0);
        chk("rst fetch_err", {31'd0, fetch_err}, 0);

        run = 1'b1;
        rst_n = 1'b1;
        wait_sig(1, "first req");
        chk("t1 mem_addr", {16'd0, mem_addr}, 0);
        wait_sig(0, "t1 valid");
        chk("t1 sel", {28'd0, sel}, 1);
        chk("t1 data1", {16'd0, data1_out}, 1);
        chk("t1 data2", {16'd0, data2_out}, 2);
        chk("t1 data3", {16'd0, data3_out}, 3);

        push(0, 0, 16'h0000);
        wait_sig(1, "t2 req a");
        chk("t2 plain addr", {16'd0, mem_addr}, 1);
        wait_sig(0, "t2 valid");
        chk("t2 data1", {16'd0, data1_out}, 4);
        push(0, 1, 16'h0001);
        wait_sig(1, "t2 req b");
        chk("t2 offset addr", {16'd0, mem_addr}, 2);

        wait_sig(0, "t3 valid a");
        push(1, 0, 16'h0040);
        wait_sig(1, "t3 req a");
        chk("t3 load addr", {16'd0, mem_addr}, 16'h0040);
        wait_sig(0, "t3 valid b");
        push(1, 1, 16'h0100);
        wait_sig(1, "t3 req b");
        chk("t3 load+offset addr", {16'd0, mem_addr}, 16'h0100);

        wait_sig(0, "t4 valid a");
        chk("t4 jump sel", {28'd0, sel}, 15);
        chk("t4 jump data1", {16'd0, data1_out}, 16'h0ABC);
        push(1, 0, 16'hFFFF);
        wait_sig(1, "t4 req a");
        chk("t4 addr ffff", {16'd0, mem_addr}, 16'hFFFF);
        wait_sig(0, "t4 valid b");
        push(0, 0, 16'h0000);
        wait_sig(1, "t4 req b");
        chk("t4 wrap addr", {16'd0, mem_addr}, 0);

        // Drop run while an instruction is issued.
        wait_sig(0, "t6 valid");
        run = 1'b0;
        cyc(3);
        push(0, 0, 16'h0000);
        cyc(6);
        chk("t6 idle mem_req", {31'd0, mem_req}, 0);
        chk("t6 idle pc", {16'd0, pc}, 1);
        force_exec = 1'b1;
        cyc(1);
        force_exec = 1'b0;
        cyc(2);
        chk("exec outside issue pc", {16'd0, pc}, 1);

        // Drop run during a stalled request; the fetch still completes.
        ack_en = 1'b0;
        run = 1'b1;
        wait_sig(1, "runreq req");
        run = 1'b0;
        cyc(3);
        ack_en = 1'b1;
        wait_sig(0, "runreq valid");
        chk("runreq sel", {28'd0, sel}, 2);
        mem[1] = 16'h9999;
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        cyc(1);
        chk("stray ack sel", {28'd0, sel}, 2);
        chk("stray ack data1", {16'd0, data1_out}, 4);
        push(0, 1, 16'h0003);
        cyc(6);
        chk("runreq idle mem_req", {31'd0, mem_req}, 0);
        chk("runreq pc", {16'd0, pc}, 4);

        // Asynchronous reset in the middle of a request.
        ack_en = 1'b0;
        run = 1'b1;
        wait_sig(1, "midrst req");
        chk("midrst addr", {16'd0, mem_addr}, 4);
        cyc(2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst mem_req", {31'd0, mem_req}, 0);
        chk("midrst pc", {16'd0, pc}, 0);
        chk("midrst sel", {28'd0, sel}, 0);
        cyc(2);
        ack_en = 1'b1;
        rst_n = 1'b1;
        wait_sig(0, "midrst valid");
        chk("midrst refetch sel", {28'd0, sel}, 1);

        // Ack on the last allowed wait cycle wins over the timeout.
        ack_en = 1'b0;
        push(0, 0, 16'h0000);
        wait_sig(1, "edge req");
        chk("edge addr", {16'd0, mem_addr}, 1);
        cyc(MAXW - 1);
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        chk("edge valid", {31'd0, instr_valid}, 1);
        chk("edge err", {31'd0, fetch_err}, 0);
        chk("edge sel", {28'd0, sel}, 9);

        // Timeout into HALT.
        push(0, 0, 16'h0000);
        wait_sig(1, "to req");
        n = 1;
        while (n < 400) begin
            cyc(1);
            if (!mem_req) break;
            n++;
        end
        chk("to req cycles", n, MAXW);
        chk("to err", {31'd0, fetch_err}, 1);
        chk("to mem_req", {31'd0, mem_req}, 0);
        ack_en = 1'b1;
        force_ack = 1'b1;
        cyc(4);
        force_ack = 1'b0;
        chk("halt mem_req", {31'd0, mem_req}, 0);
        chk("halt valid", {31'd0, instr_valid}, 0);
        chk("halt err", {31'd0, fetch_err}, 1);
        chk("halt pc", {16'd0, pc}, 2);
        run = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("halt rst err", {31'd0, fetch_err}, 0);
        chk("halt rst pc", {16'd0, pc}, 0);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
